// File: rtl/pipelined_csel_adder.sv
// -----------------------------------------------------------------------------
// pipelined_csel_adder
//
// Pipelined carry-select adder/subtractor with valid/ready handshakes on both
// sides. The operands are cut into BLK-bit blocks. Block 0 is resolved as the
// beat is accepted. Each later pipeline stage resolves one more block: it
// computes that block for carry-in 0 and carry-in 1 in parallel and selects
// with the carry registered by the stage below. The result appears NB = N/BLK
// cycles after acceptance, and one operation can be accepted per cycle.
//
// Parameters
//   N    operand/result width; must be a multiple of BLK
//   BLK  block width resolved per stage, 1 <= BLK <= N
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset; discards everything in flight
//   in_valid   operand beat present
//   in_ready   a beat is accepted this cycle (low while rst or stalled)
//   A, B       operands
//   Cin        carry-in, used for add and for subtract
//   sub        0: A + B + Cin, 1: A + ~B + Cin (drive Cin = 1 for A - B)
//   out_valid  result beat present
//   out_ready  consumer takes the result this cycle
//   Sum        result, modulo 2^N
//   Cout       carry out of bit N-1 (subtract: 1 = no borrow)
//   Ovf        signed overflow, carry into bit N-1 XOR Cout
// -----------------------------------------------------------------------------
module pipelined_csel_adder #(
   parameter int N   = 32,
   parameter int BLK = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         Cin,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] Sum,
   output logic         Cout,
   output logic         Ovf
);

   // Stage count, which is also the latency in cycles.
   localparam int NB = N / BLK;

   // Result of rippling one block.
   typedef struct packed {
      logic [BLK-1:0] s;     // block sum bits
      logic           co;    // carry out of the block
      logic           ctop;  // carry into the block's most significant bit
   } blk_res_t;

   // One pipeline register. Bits of sum above the resolved blocks are zero;
   // a and be keep the whole operand so the upper blocks travel unchanged.
   typedef struct packed {
      logic         valid;
      logic         carry;  // carry into the next unresolved block; Cout in the last stage
      logic         cmsb;   // carry into bit N-1, set once the top block is resolved
      logic [N-1:0] sum;
      logic [N-1:0] a;
      logic [N-1:0] be;     // B after the optional inversion for subtract
   } stage_t;

   // Plain ripple-carry add of one block.
   function automatic blk_res_t ripple(
      input logic [BLK-1:0] a,
      input logic [BLK-1:0] b,
      input logic           ci
   );
      blk_res_t r;
      logic     c;
      r = '0;
      c = ci;
      for (int i = 0; i < BLK; i++) begin
         if (i == BLK - 1) r.ctop = c;
         r.s[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      r.co = c;
      return r;
   endfunction

   stage_t       stg [NB];  // stg[k] is stage S(k+1)
   stage_t       nxt [NB];  // value each stage captures when the pipe advances
   logic         stall;
   logic [N-1:0] be_in;
   blk_res_t     r_in;
   blk_res_t     r_lo;
   blk_res_t     r_hi;
   blk_res_t     r_sel;

   // The whole pipe freezes while the consumer refuses a present result, so
   // beats never overtake each other and bubbles stay where they are.
   assign stall    = stg[NB-1].valid && !out_ready;
   assign in_ready = !rst && !stall;

   always_comb begin
      // NOTE: every variable written here gets a default before any branch or
      // loop, so no path can leave a value unassigned and infer a latch.
      r_lo  = '0;
      r_hi  = '0;
      r_sel = '0;

      // NOTE: blocking assignments inside combinational logic; the loop below
      // reads temporaries it has just written in the same iteration.
      be_in = B ^ {N{sub}};
      r_in  = ripple(A[BLK-1:0], be_in[BLK-1:0], Cin);

      // Entry stage: block 0 resolved directly with the external carry-in.
      nxt[0]                = '0;
      nxt[0].valid          = in_valid;
      nxt[0].a              = A;
      nxt[0].be             = be_in;
      nxt[0].sum[BLK-1:0]   = r_in.s;
      nxt[0].carry          = r_in.co;
      // With a single stage block 0 is also the top block.
      nxt[0].cmsb           = (NB == 1) ? r_in.ctop : 1'b0;

      // Stage k resolves block k from what stage k-1 holds. Both carry
      // hypotheses are rippled in parallel; the registered carry only drives
      // the final mux, keeping the stage path to one block ripple plus a mux.
      for (int k = 1; k < NB; k++) begin
         r_lo  = ripple(stg[k-1].a[k*BLK +: BLK], stg[k-1].be[k*BLK +: BLK], 1'b0);
         r_hi  = ripple(stg[k-1].a[k*BLK +: BLK], stg[k-1].be[k*BLK +: BLK], 1'b1);
         r_sel = stg[k-1].carry ? r_hi : r_lo;

         nxt[k]                    = stg[k-1];
         nxt[k].sum[k*BLK +: BLK]  = r_sel.s;
         nxt[k].carry              = r_sel.co;
         if (k == NB - 1) nxt[k].cmsb = r_sel.ctop;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: data fields are cleared along with the valid bits so the
         // outputs read zero after reset, not just out_valid.
         for (int k = 0; k < NB; k++) stg[k] <= '0;
      end else if (!stall) begin
         // NOTE: non-blocking assignments so every stage captures the value
         // its neighbour held before this edge.
         for (int k = 0; k < NB; k++) stg[k] <= nxt[k];
      end
   end

   assign out_valid = stg[NB-1].valid;
   assign Sum       = stg[NB-1].sum;
   assign Cout      = stg[NB-1].carry;
   assign Ovf       = stg[NB-1].cmsb ^ stg[NB-1].carry;

endmodule
